round_ctrl: RTL and testbench

Round sequencer for the memory game. Drives the three-level chooser FSM through its `en`/`ans`/`life` inputs:
- latches the pattern when the chooser requests display (`disp`);
- shows the pattern for a level-scaled time, then collects the player's cell selections;
- compares the answer and manages lives.

It sits between the level chooser, the pattern source, the button decoder and the 4x4 LED grid driver.

---
 rtl/round_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_round_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_ctrl.sv
// Round sequencer for the memory game: latches a pattern, shows it, collects the guess, scores it.
// All outputs registered; step_en/ans are single-cycle pulses toward the level chooser.
module round_ctrl #(
    parameter int SHOW_TICKS  = 8,
    parameter int INPUT_TICKS = 200,
    parameter int RES_TICKS   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        disp,
    input  logic [1:0]  level,
    input  logic [15:0] pattern_in,
    input  logic        btn_valid,
    input  logic [3:0]  btn_idx,
    input  logic        submit,
    output logic        step_en,
    output logic        ans,
    output logic [1:0]  life,
    output logic [15:0] led,
    output logic        ok,
    output logic        err,
    output logic        game_over,
    output logic [3:0]  rounds
);

    typedef enum logic [2:0] {
        S_IDLE, S_SHOW, S_INPUT, S_CHECK, S_RESULT, S_OVER
    } state_t;

    localparam logic [7:0] SHOW_1X = 8'(SHOW_TICKS);
    localparam logic [7:0] SHOW_2X = 8'(2 * SHOW_TICKS);
    localparam logic [7:0] SHOW_3X = 8'(3 * SHOW_TICKS);
    localparam logic [7:0] SHOW_4X = 8'(4 * SHOW_TICKS);
    localparam logic [7:0] IN_LEN  = 8'(INPUT_TICKS);
    localparam logic [7:0] RES_LEN = 8'(RES_TICKS);

    state_t      state_q, state_d;
    logic [15:0] pat_q, pat_d;
    logic [15:0] guess_q, guess_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  show_len_q, show_len_d;
    logic [1:0]  life_q, life_d;
    logic [3:0]  rounds_q, rounds_d;
    logic [15:0] led_q, led_d;
    logic        step_en_q, step_en_d;
    logic        ans_q, ans_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic        game_over_q, game_over_d;

    logic [7:0]  cnt_inc;
    logic [15:0] guess_tog;

    assign cnt_inc   = cnt_q + 8'd1;
    assign guess_tog = guess_q ^ (btn_valid ? (16'h0001 << btn_idx) : 16'h0000);

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        guess_d     = guess_q;
        cnt_d       = cnt_q;
        show_len_d  = show_len_q;
        life_d      = life_q;
        rounds_d    = rounds_q;
        led_d       = led_q;
        step_en_d   = 1'b0;
        ans_d       = 1'b0;
        ok_d        = ok_q;
        err_d       = err_q;
        game_over_d = game_over_q;

        case (state_q)
            S_IDLE: begin
                led_d = 16'h0000;
                if (disp && life_q != 2'd0) begin
                    pat_d     = pattern_in;
                    guess_d   = 16'h0000;
                    cnt_d     = 8'd0;
                    led_d     = pattern_in;
                    step_en_d = 1'b1;
                    state_d   = S_SHOW;
                    case (level)
                        2'b01:   show_len_d = SHOW_3X;
                        2'b10:   show_len_d = SHOW_2X;
                        2'b11:   show_len_d = SHOW_1X;
                        default: show_len_d = SHOW_4X;
                    endcase
                end
            end
            S_SHOW: begin
                led_d = pat_q;
                if (tick) begin
                    if (cnt_inc == show_len_q) begin
                        cnt_d   = 8'd0;
                        led_d   = guess_q;
                        state_d = S_INPUT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_INPUT: begin
                // Toggle lands before the submit so a same-cycle press is scored.
                guess_d = guess_tog;
                led_d   = guess_tog;
                if (tick) cnt_d = cnt_inc;
                if (submit || (tick && cnt_inc == IN_LEN)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d = 8'd0;
                if (guess_q == pat_q) begin
                    if (rounds_q != 4'hF) rounds_d = rounds_q + 4'd1;
                    ok_d      = 1'b1;
                    led_d     = 16'hFFFF;
                    step_en_d = 1'b1;
                    ans_d     = 1'b1;
                    state_d   = S_RESULT;
                end else if (life_q > 2'd1) begin
                    life_d  = life_q - 2'd1;
                    err_d   = 1'b1;
                    led_d   = 16'h0000;
                    state_d = S_RESULT;
                end else begin
                    life_d      = 2'd0;
                    led_d       = 16'h0000;
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end
            end
            S_RESULT: begin
                if (tick) begin
                    if (cnt_inc == RES_LEN) begin
                        cnt_d = 8'd0;
                        ok_d  = 1'b0;
                        err_d = 1'b0;
                        if (ok_q) begin
                            led_d   = 16'h0000;
                            state_d = S_IDLE;
                        end else begin
                            // Replay the same pattern without advancing the chooser.
                            guess_d = 16'h0000;
                            led_d   = pat_q;
                            state_d = S_SHOW;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_OVER: begin
                led_d       = 16'h0000;
                life_d      = 2'd0;
                game_over_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pat_q       <= 16'h0000;
            guess_q     <= 16'h0000;
            cnt_q       <= 8'd0;
            show_len_q  <= 8'd0;
            life_q      <= 2'd3;
            rounds_q    <= 4'd0;
            led_q       <= 16'h0000;
            step_en_q   <= 1'b0;
            ans_q       <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            guess_q     <= guess_d;
            cnt_q       <= cnt_d;
            show_len_q  <= show_len_d;
            life_q      <= life_d;
            rounds_q    <= rounds_d;
            led_q       <= led_d;
            step_en_q   <= step_en_d;
            ans_q       <= ans_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            game_over_q <= game_over_d;
        end
    end

    assign step_en   = step_en_q;
    assign ans       = ans_q;
    assign life      = life_q;
    assign led       = led_q;
    assign ok        = ok_q;
    assign err       = err_q;
    assign game_over = game_over_q;
    assign rounds    = rounds_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with short show/input/result windows.
module tb_round_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        disp = 1'b0;
    logic [1:0]  level = 2'b01;
    logic [15:0] pattern_in = 16'h0000;
    logic        btn_valid = 1'b0;
    logic [3:0]  btn_idx = 4'd0;
    logic        submit = 1'b0;
    logic        step_en, ans, ok, err, game_over;
    logic [1:0]  life;
    logic [15:0] led;
    logic [3:0]  rounds;

    int n_tests = 0;
    int n_fail  = 0;

    round_ctrl #(.SHOW_TICKS(2), .INPUT_TICKS(5), .RES_TICKS(2)) dut (
        .clk(clk), .reset(reset), .tick(tick), .disp(disp), .level(level),
        .pattern_in(pattern_in), .btn_valid(btn_valid), .btn_idx(btn_idx),
        .submit(submit), .step_en(step_en), .ans(ans), .life(life), .led(led),
        .ok(ok), .err(err), .game_over(game_over), .rounds(rounds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tk();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic start(input logic [1:0] lvl, input logic [15:0] p);
        level = lvl;
        pattern_in = p;
        disp = 1'b1;
        cyc();
        disp = 1'b0;
        chk("start_step", step_en, 1);
        chk("start_led", led, p);
    endtask

    task automatic sel(input logic [3:0] idx);
        btn_valid = 1'b1;
        btn_idx = idx;
        cyc();
        btn_valid = 1'b0;
    endtask

    task automatic sub();
        submit = 1'b1;
        cyc();
        submit = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0]  lvl;
        logic [15:0] p;
        int          exp_r;

        cyc();
        do_reset();
        chk("rst_led", led, 0);
        chk("rst_life", life, 3);
        chk("rst_rounds", rounds, 0);
        chk("rst_pulses", {step_en, ans, ok, err, game_over}, 0);

        // Correct round at level 01: 6 ticks of show
        start(2'b01, 16'h0041);
        cyc();
        chk("r1_step_drop", step_en, 0);
        repeat (5) tk();
        chk("r1_show_5", led, 16'h0041);
        tk();
        chk("r1_input_led", led, 16'h0000);
        sel(4'd0);
        chk("r1_sel0", led, 16'h0001);
        sel(4'd6);
        chk("r1_sel6", led, 16'h0041);
        sub();
        chk("r1_res_led", led, 16'hFFFF);
        chk("r1_res_pulse", {step_en, ans, ok}, 3'b111);
        chk("r1_rounds", rounds, 1);
        chk("r1_life", life, 3);
        cyc();
        chk("r1_pulse_once", {step_en, ans}, 0);
        tk();
        tk();
        chk("r1_idle_led", led, 0);
        chk("r1_ok_drop", ok, 0);

        // Wrong answer, replay, then correct
        start(2'b11, 16'h0003);
        tk();
        tk();
        sel(4'd0);
        sub();
        chk("w_life", life, 2);
        chk("w_err", err, 1);
        chk("w_nostep", {step_en, ans}, 0);
        chk("w_led", led, 0);
        tk();
        tk();
        chk("w_replay_led", led, 16'h0003);
        chk("w_replay_nostep", step_en, 0);
        tk();
        tk();
        chk("w_input_cleared", led, 0);
        sel(4'd0);
        sel(4'd1);
        sub();
        chk("w2_ans", {step_en, ans, ok}, 3'b111);
        chk("w2_rounds", rounds, 2);
        tk();
        tk();

        // Inputs in SHOW ignored; simultaneous toggle+submit scored
        start(2'b11, 16'h0011);
        btn_valid = 1'b1; btn_idx = 4'd5; submit = 1'b1;
        cyc();
        btn_valid = 1'b0; submit = 1'b0;
        chk("sh_ignore_led", led, 16'h0011);
        tk();
        tk();
        chk("sh_ignore_guess", led, 16'h0000);
        sel(4'd0);
        btn_valid = 1'b1; btn_idx = 4'd4; submit = 1'b1;
        cyc();
        btn_valid = 1'b0; submit = 1'b0;
        chk("sim_check_led", led, 16'h0011);
        cyc();
        chk("sim_ok", ok, 1);
        chk("sim_rounds", rounds, 3);
        tk();
        tk();

        // Timeout on the 5th input tick
        start(2'b11, 16'h0003);
        tk();
        tk();
        repeat (4) tk();
        chk("to_before_err", err, 0);
        chk("to_before_life", life, 2);
        tk();
        chk("to_err", err, 1);
        chk("to_life", life, 1);

        // Game over after three wrong answers
        do_reset();
        start(2'b11, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            tk();
            tk();
            sub();
            chk("go_life", life, 2 - i);
            if (i < 2) begin
                tk();
                tk();
                chk("go_replay", led, 16'h0003);
            end
        end
        chk("go_flag", game_over, 1);
        chk("go_led", led, 0);
        level = 2'b11; pattern_in = 16'hFFFF; disp = 1'b1;
        cyc();
        disp = 1'b0;
        sel(4'd3);
        sub();
        tk();
        chk("go_hold", {game_over, life, led, step_en, ans, ok, err}, {1'b1, 2'd0, 16'h0, 4'h0});

        // Reset in the middle of INPUT
        do_reset();
        chk("go_reset_life", life, 3);
        start(2'b11, 16'h1234);
        tk();
        tk();
        for (int i = 4; i < 8; i++) sel(4'(i));
        chk("mid_guess", led, 16'h00F0);
        do_reset();
        chk("mid_rst_led", led, 0);
        chk("mid_rst_all", {step_en, ans, ok, err, game_over, life, rounds}, {5'b0, 2'd3, 4'd0});
        start(2'b01, 16'hA5A5);
        do_reset();

        // Level cycling, rounds saturation
        for (int r = 0; r < 16; r++) begin
            lvl = 2'(r % 3 + 1);
            p = 16'h0001 << r;
            exp_r = (r + 1 > 15) ? 15 : r + 1;
            start(lvl, p);
            repeat (2 * (4 - int'(lvl)) - 1) tk();
            chk("lc_show", led, p);
            tk();
            chk("lc_input", led, 0);
            sel(4'(r));
            sub();
            chk("lc_ok", ok, 1);
            chk("lc_rounds", rounds, exp_r);
            tk();
            tk();
            chk("lc_idle", led, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
